// File: rtl/fp16_pkg.sv
// Shared binary16 field widths, special encodings and field classification helpers.
package fp16_pkg;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] PINF = 16'h7C00;
  localparam logic [15:0] NINF = 16'hFC00;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp16_t;

  // Subnormals count as zero because they are flushed on input.
  function automatic logic fp_is_zero(input fp16_t x);
    return x.exp == {EXP_W{1'b0}};
  endfunction

  function automatic logic fp_is_inf(input fp16_t x);
    return (x.exp == {EXP_W{1'b1}}) && (x.man == {MAN_W{1'b0}});
  endfunction

  function automatic logic fp_is_nan(input fp16_t x);
    return (x.exp == {EXP_W{1'b1}}) && (x.man != {MAN_W{1'b0}});
  endfunction
endpackage

// File: rtl/cla_adder.sv
// Parameterized adder built from 4-bit carry-lookahead blocks; W must be a multiple of 4.
module cla_adder #(
  parameter int W = 28
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  localparam int NB = W / 4;

  logic [W-1:0] g_s;
  logic [W-1:0] p_s;
  logic [W-1:0] c_s;
  logic [NB:0]  bc_s;

  // In-block lookahead carries; block carry-out formed from block generate/propagate.
  always_comb begin
    g_s     = a & b;
    p_s     = a ^ b;
    c_s     = {W{1'b0}};
    bc_s    = {(NB+1){1'b0}};
    bc_s[0] = cin;
    for (int k = 0; k < NB; k++) begin
      c_s[4*k]   = bc_s[k];
      c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & bc_s[k]);
      c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+1] & p_s[4*k] & bc_s[k]);
      c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & bc_s[k]);
      bc_s[k+1]  = g_s[4*k+3] | (p_s[4*k+3] & g_s[4*k+2])
                 | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & bc_s[k]);
    end
    s    = p_s ^ c_s;
    cout = bc_s[NB];
  end
endmodule

// File: rtl/fp_mac.sv
// Binary16 multiply-add out = in*weight + acc, single truncation, 2-register pipeline.
// Define FPMAC_CLA_ADDER_EN to build the stage-2 significand adder from cla_adder blocks.
module fp_mac
  import fp16_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] in,
  input  logic [15:0] weight,
  input  logic [15:0] acc,
  output logic [15:0] out,
  output logic        overflow,
  output logic        sub
);
  // 22-bit significand in [27:6]; the six low bits hold guard bits and the sticky in bit 0.
  localparam int SW = 28;
  localparam logic signed [7:0] ZERO_EXP = -8'sd64;

  fp16_t a_s, b_s, c_s;
  logic a_zero_s, b_zero_s, c_zero_s, a_inf_s, b_inf_s, c_inf_s, any_nan_s;
  logic p_inf_s, p_zero_s, p_sign_s, p_big_s;
  logic [21:0] prod_s, p_sig_s, c_sig_s, big_sig_s, sml_sig_s;
  logic signed [7:0] p_exp_s, c_exp_s, big_exp_s, sml_exp_s;
  logic [7:0] shamt_s;
  logic [SW-1:0] sml_x_s, mask_s;

  logic spec_d, spec_q, sign_d, sign_q, zsign_d, zsign_q, eff_sub_d, eff_sub_q, s1_sub_d, s1_sub_q;
  logic [15:0] spec_val_d, spec_val_q;
  logic signed [7:0] exp_d, exp_q;
  logic [SW-1:0] big_d, big_q, small_d, small_q;

  logic [SW-1:0] addend_s, sum_s;
  logic cout_s;
  logic [SW:0] mag_s;
  logic [4:0] lead_s;
  logic signed [7:0] res_exp_s;
  logic [9:0] mant_s;
  logic [15:0] out_d, out_q;
  logic ovf_d, ovf_q, sub_d, sub_q;

  // Stage 1: exact product, special-case detection, operand ordering and alignment.
  always_comb begin
    a_s = fp16_t'(in);
    b_s = fp16_t'(weight);
    c_s = fp16_t'(acc);
    a_zero_s  = fp_is_zero(a_s);
    b_zero_s  = fp_is_zero(b_s);
    c_zero_s  = fp_is_zero(c_s);
    a_inf_s   = fp_is_inf(a_s);
    b_inf_s   = fp_is_inf(b_s);
    c_inf_s   = fp_is_inf(c_s);
    any_nan_s = fp_is_nan(a_s) | fp_is_nan(b_s) | fp_is_nan(c_s);
    p_inf_s   = a_inf_s | b_inf_s;
    p_zero_s  = a_zero_s | b_zero_s;
    p_sign_s  = a_s.sign ^ b_s.sign;
    prod_s    = {11'd0, 1'b1, a_s.man} * {11'd0, 1'b1, b_s.man};

    if (p_zero_s) begin
      p_sig_s = 22'd0;
      p_exp_s = ZERO_EXP;
    end else if (prod_s[21]) begin
      p_sig_s = prod_s;
      p_exp_s = $signed({3'b000, a_s.exp}) + $signed({3'b000, b_s.exp}) - 8'(BIAS) + 8'sd1;
    end else begin
      p_sig_s = {prod_s[20:0], 1'b0};
      p_exp_s = $signed({3'b000, a_s.exp}) + $signed({3'b000, b_s.exp}) - 8'(BIAS);
    end

    if (c_zero_s) begin
      c_sig_s = 22'd0;
      c_exp_s = ZERO_EXP;
    end else begin
      c_sig_s = {1'b1, c_s.man, 11'd0};
      c_exp_s = $signed({3'b000, c_s.exp});
    end

    // Larger magnitude goes first so an effective subtraction never goes negative.
    p_big_s = (p_exp_s > c_exp_s) || ((p_exp_s == c_exp_s) && (p_sig_s >= c_sig_s));
    if (p_big_s) begin
      big_sig_s = p_sig_s;  big_exp_s = p_exp_s;  sign_d = p_sign_s;
      sml_sig_s = c_sig_s;  sml_exp_s = c_exp_s;
    end else begin
      big_sig_s = c_sig_s;  big_exp_s = c_exp_s;  sign_d = c_s.sign;
      sml_sig_s = p_sig_s;  sml_exp_s = p_exp_s;
    end

    shamt_s = 8'(big_exp_s - sml_exp_s);
    sml_x_s = {sml_sig_s, 6'd0};
    mask_s  = ~({SW{1'b1}} << shamt_s);
    small_d = (sml_x_s >> shamt_s) | {{(SW-1){1'b0}}, |(sml_x_s & mask_s)};
    big_d   = {big_sig_s, 6'd0};
    exp_d   = big_exp_s;

    eff_sub_d = p_sign_s ^ c_s.sign;
    zsign_d   = p_sign_s & c_s.sign;
    spec_d    = any_nan_s | p_inf_s | c_inf_s;
    s1_sub_d  = eff_sub_d & ~p_zero_s & ~c_zero_s & ~spec_d;

    if (any_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)
        || (p_inf_s && c_inf_s && eff_sub_d)) begin
      spec_val_d = QNAN;
    end else if (p_inf_s) begin
      spec_val_d = p_sign_s ? NINF : PINF;
    end else if (c_inf_s) begin
      spec_val_d = c_s.sign ? NINF : PINF;
    end else begin
      spec_val_d = 16'h0000;
    end
  end

  // Stage 1 pipeline register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      spec_q <= 1'b0;  spec_val_q <= 16'h0000;  sign_q <= 1'b0;  zsign_q <= 1'b0;
      eff_sub_q <= 1'b0;  s1_sub_q <= 1'b0;  exp_q <= 8'sd0;
      big_q <= {SW{1'b0}};  small_q <= {SW{1'b0}};
    end else begin
      spec_q <= spec_d;  spec_val_q <= spec_val_d;  sign_q <= sign_d;  zsign_q <= zsign_d;
      eff_sub_q <= eff_sub_d;  s1_sub_q <= s1_sub_d;  exp_q <= exp_d;
      big_q <= big_d;  small_q <= small_d;
    end
  end

  assign addend_s = eff_sub_q ? ~small_q : small_q;

`ifdef FPMAC_CLA_ADDER_EN
  cla_adder #(.W(SW)) u_cla_adder (
    .a    (big_q),
    .b    (addend_s),
    .cin  (eff_sub_q),
    .s    (sum_s),
    .cout (cout_s)
  );
`else
  // Behavioural significand adder.
  always_comb begin
    {cout_s, sum_s} = {1'b0, big_q} + {1'b0, addend_s} + {{SW{1'b0}}, eff_sub_q};
  end
`endif

  // Stage 2: normalize, truncate and classify the result.
  always_comb begin
    mag_s  = {cout_s ^ eff_sub_q, sum_s};
    lead_s = 5'd0;
    for (int i = 0; i <= SW; i++) begin
      lead_s = mag_s[i] ? 5'(i) : lead_s;
    end
    res_exp_s = exp_q + $signed({3'b000, lead_s}) - 8'(SW - 1);
    mant_s    = 10'({mag_s, 10'd0} >> lead_s);
    sub_d     = s1_sub_q;
    ovf_d     = 1'b0;
    if (spec_q) begin
      out_d = spec_val_q;
    end else if (mag_s == {(SW+1){1'b0}}) begin
      out_d = {zsign_q, 15'd0};
    end else if (res_exp_s > 8'sd30) begin
      out_d = sign_q ? NINF : PINF;
      ovf_d = 1'b1;
    end else if (res_exp_s < 8'sd1) begin
      out_d = {sign_q, 15'd0};
    end else begin
      out_d = {sign_q, res_exp_s[4:0], mant_s};
    end
  end

  // Stage 2 output register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_q <= 16'h0000;  ovf_q <= 1'b0;  sub_q <= 1'b0;
    end else begin
      out_q <= out_d;  ovf_q <= ovf_d;  sub_q <= sub_d;
    end
  end

  assign out      = out_q;
  assign overflow = ovf_q;
  assign sub      = sub_q;
endmodule

// File: tb/tb_fp_mac.sv
// Directed bench for fp_mac: expected results queued at drive time, compared when due.
module tb_fp_mac;
  logic        clk;
  logic        rst;
  logic [15:0] in_d, w_d, acc_d;
  logic [15:0] out_w;
  logic        ovf_w, sub_w;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] o;
    logic        ov;
    logic        sb;
    int          due;
    string       tag;
  } exp_t;
  exp_t sb_q[$];

  fp_mac dut (
    .CLK      (clk),
    .RST      (rst),
    .in       (in_d),
    .weight   (w_d),
    .acc      (acc_d),
    .out      (out_w),
    .overflow (ovf_w),
    .sub      (sub_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cmp1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_due();
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      cmp16({e.tag, ".out"}, out_w, e.o);
      cmp1({e.tag, ".overflow"}, ovf_w, e.ov);
      cmp1({e.tag, ".sub"}, sub_w, e.sb);
    end
  endtask

  // One cycle: compare anything due, then drive new inputs and optionally queue a result.
  task automatic step(input logic [15:0] a, input logic [15:0] w, input logic [15:0] c,
                      input bit push, input logic [15:0] eo, input logic eov,
                      input logic esb, input string tag);
    exp_t e;
    @(negedge clk);
    check_due();
    in_d  = a;
    w_d   = w;
    acc_d = c;
    if (push) begin
      e.o = eo;  e.ov = eov;  e.sb = esb;  e.due = cyc + 2;  e.tag = tag;
      sb_q.push_back(e);
    end
  endtask

  initial begin
    rst = 1'b1;  in_d = 16'h0000;  w_d = 16'h0000;  acc_d = 16'h0000;
    #1;
    cmp16("reset.out", out_w, 16'h0000);
    cmp1("reset.overflow", ovf_w, 1'b0);
    cmp1("reset.sub", sub_w, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    step(16'h3C00, 16'h4000, 16'h3C00, 1'b1, 16'h4200, 1'b0, 1'b0, "one_times_two_plus_one");
    step(16'h4000, 16'h4200, 16'hC400, 1'b1, 16'h4000, 1'b0, 1'b1, "six_minus_four");
    step(16'h3C00, 16'hBC00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b1, "exact_cancel");
    step(16'h7BFF, 16'h4000, 16'h0000, 1'b1, 16'h7C00, 1'b1, 1'b0, "overflow_pos");
    step(16'h7C00, 16'h0000, 16'h3C00, 1'b1, 16'h7E00, 1'b0, 1'b0, "inf_times_zero");
    step(16'h3C00, 16'h7D00, 16'h0000, 1'b1, 16'h7E00, 1'b0, 1'b0, "nan_input");
    step(16'h7C00, 16'h3C00, 16'hFC00, 1'b1, 16'h7E00, 1'b0, 1'b0, "inf_minus_inf");
    step(16'hFC00, 16'h4000, 16'h3C00, 1'b1, 16'hFC00, 1'b0, 1'b0, "neg_inf_product");
    step(16'h3C00, 16'h3C00, 16'h7C00, 1'b1, 16'h7C00, 1'b0, 1'b0, "inf_acc");
    step(16'h0001, 16'h3C00, 16'h3C00, 1'b1, 16'h3C00, 1'b0, 1'b0, "subnormal_in_flushed");
    step(16'h8400, 16'h3800, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b0, "subnormal_result_flushed");
    step(16'h3C01, 16'h3C03, 16'hBC00, 1'b1, 16'h1C00, 1'b0, 1'b1, "truncate_not_nearest");
    step(16'h3C00, 16'h3C00, 16'h9001, 1'b1, 16'h3BFE, 1'b0, 1'b1, "truncate_below_one");
    step(16'h0401, 16'h3C01, 16'hDC00, 1'b1, 16'hDBFF, 1'b0, 1'b1, "sticky_subtract");
    step(16'h8000, 16'h3C00, 16'h8000, 1'b1, 16'h8000, 1'b0, 1'b0, "neg_zero_sum");
    step(16'hFBFF, 16'h4000, 16'h0000, 1'b1, 16'hFC00, 1'b1, 1'b0, "overflow_neg");
    step(16'h7BFF, 16'h3C00, 16'h0000, 1'b1, 16'h7BFF, 1'b0, 1'b0, "max_finite");
    step(16'h7BFF, 16'h4000, 16'hFBFF, 1'b1, 16'h7BFF, 1'b0, 1'b1, "big_product_pulled_back");

    // Reset while two results are in flight.
    step(16'h3C00, 16'h4000, 16'h3C00, 1'b1, 16'h4200, 1'b0, 1'b0, "pre_reset_a");
    step(16'h4000, 16'h4200, 16'hC400, 1'b1, 16'h4000, 1'b0, 1'b1, "pre_reset_b");
    @(posedge clk);
    #1;
    cmp16("pre_reset_visible.out", out_w, 16'h4200);
    #1 rst = 1'b1;
    #1;
    sb_q.delete();
    cmp16("mid_reset.out", out_w, 16'h0000);
    cmp1("mid_reset.overflow", ovf_w, 1'b0);
    cmp1("mid_reset.sub", sub_w, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    step(16'h4000, 16'h4200, 16'hC400, 1'b1, 16'h4000, 1'b0, 1'b1, "post_reset_1");
    step(16'h7BFF, 16'h4000, 16'h0000, 1'b1, 16'h7C00, 1'b1, 1'b0, "post_reset_2");
    step(16'h3C00, 16'h4000, 16'h3C00, 1'b1, 16'h4200, 1'b0, 1'b0, "post_reset_3");

    for (int i = 0; i < 4; i++) begin
      step(16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "drain");
    end
    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
